date_set_controller: RTL and testbench
======================================

Name: date_set_controller

Overview:
User-edit sequencer for date_module. It captures the running date, lets the user step through day, month and year with mode/inc/dec/cancel button pulses, and clamps the day to the month length. On commit it drives date_in and issues a single-cycle date_ow pulse. It sits between the debounced button front end and date_module, and shares date_module's packed date format.

Parameters:
YEARRES, 12, year field width; date word is YEARRES+9 bits, packed {day[4:0], month[3:0], year[YEARRES-1:0]}.
TIMEOUT_CYCLES, 32'd100_000_000, idle-edit abort limit (used only with the optional feature).

Ports:
clk  input  1  system clock, sole clock.
rst  input  1  synchronous, active-high reset.
date_current  input  YEARRES+9  live date from date_module (date_out).
btn_mode  input  1  one-cycle pulse: enter edit / advance field.
btn_inc  input  1  one-cycle pulse: increment active field.
btn_dec  input  1  one-cycle pulse: decrement active field.
btn_cancel  input  1  one-cycle pulse: abort edit.
date_in  output  YEARRES+9  edit buffer; goes to date_module date_in.
date_ow  output  1  overwrite strobe to date_module; exactly 1 cycle high.
editing  output  1  high in EDIT_DAY, EDIT_MONTH or EDIT_YEAR.
field_sel  output  2  active field for display blink: 0 none, 1 day, 2 month, 3 year.

Behaviour:
- Reset (rst high at a clk edge): state IDLE, date_in=0, date_ow=0, editing=0, field_sel=0. Reset mid-edit or mid-commit aborts with no date_ow pulse.
- States: IDLE, EDIT_DAY, EDIT_MONTH, EDIT_YEAR, COMMIT, WRITE.
- IDLE: on btn_mode, date_current is registered into the buffer and the state becomes EDIT_DAY on the next cycle. btn_inc, btn_dec and btn_cancel are ignored in IDLE.
- Capture sanitising: month 0 or 13-15 becomes 1; day 0 becomes 1; day above the month maximum is clamped to the maximum.
- Month maximum is a function of buffer month and year: month 2 gives 29 if year[1:0]==0, else 28; other even months give 30; odd months give 31. This matches date_module's rollover rule exactly.
- EDIT states:
  - btn_mode advances DAY->MONTH->YEAR->COMMIT.
  - btn_cancel returns to IDLE with no date_ow pulse; date_in keeps the buffer contents.
  - Priority: cancel > mode > inc/dec. If btn_inc and btn_dec are high in the same cycle, both are ignored.
- Field arithmetic, applied on the clk edge after the pulse:
  - Day: inc wraps max->1; dec wraps 1->max, where max is computed from the current buffer month and year.
  - Month: inc wraps 12->1; dec wraps 1->12. The day is not touched here.
  - Year: modulo 2^YEARRES; inc wraps all-ones->0, dec wraps 0->all-ones.
- COMMIT (1 cycle): day is clamped to the maximum for the final month and year, covering month/year changes made after the day was set.
- WRITE (1 cycle): date_ow=1, date_in holds the clamped value. Next state is IDLE.
  - date_in is stable from the COMMIT edge until the next capture, so date_module's asynchronous overwrite sees settled data.
  - Button pulses arriving during COMMIT or WRITE are dropped.
- Latency: the final btn_mode pulse in EDIT_YEAR is followed by COMMIT, then date_ow high one cycle later; date_ow is high in the 2nd cycle after the pulse.
- editing and field_sel are registered and change in the same cycle as the state register.

Optional Feature:
DATE_SET_TIMEOUT_EN:
- Defined: a counter in the EDIT states clears on any button pulse. When it reaches TIMEOUT_CYCLES-1, the state returns to IDLE exactly as for a cancel, with no date_ow. The counter clears on reset and in IDLE.
- Undefined: there is no counter or timeout logic, and an edit stays open indefinitely.

Decomposition:
- Shared package/header date_pkg holds:
  - state encodings;
  - FIELD_NONE/DAY/MONTH/YEAR codes;
  - date word slicing constants (day, month and year bit positions as functions of YEARRES);
  - MONTH_FEB=2, MONTH_MAX=12.
- Sub-module days_in_month: combinational, inputs month[3:0] and year[1:0], output max_day[4:0]. It is instantiated twice: once for the live buffer and once at capture/commit clamp.

Test Plan:
- Capture/commit unchanged: date_current={15,6,2020}, mode x4 -> date_ow high for exactly 1 cycle, 2 cycles after the 4th mode pulse; date_in={15,6,2020}.
- Feb wrap: capture {29,2,2020}, inc -> day 1, dec -> 29. Capture {28,2,2021}, inc -> 1.
- Clamp on commit: capture {31,1,2021}, mode, inc x3 (month 4), mode, mode -> date_in={30,4,2021}. Capture {29,2,2020}, set year 2021, commit -> day 28.
- Wraps and simultaneous buttons:
  - month 12 inc -> 1;
  - year 4095 inc -> 0 and year 0 dec -> 4095;
  - inc and dec in the same cycle -> field unchanged;
  - mode and inc in the same cycle -> field advances, value unchanged.
- Abort paths: cancel in EDIT_MONTH -> IDLE, no date_ow. rst asserted during COMMIT -> date_ow never high, all outputs 0.
- With DATE_SET_TIMEOUT_EN and TIMEOUT_CYCLES=16: enter edit, no buttons -> IDLE after 16 cycles, no date_ow. An inc at cycle 10 restarts the count.

Source files
------------

// File: rtl/date_pkg.sv
// date_pkg: shared state, field and date-word layout definitions for the date-set controller
package date_pkg;
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_EDIT_DAY   = 3'd1,
      S_EDIT_MONTH = 3'd2,
      S_EDIT_YEAR  = 3'd3,
      S_COMMIT     = 3'd4,
      S_WRITE      = 3'd5
   } state_t;
   typedef enum logic [1:0] {
      FIELD_NONE  = 2'd0,
      FIELD_DAY   = 2'd1,
      FIELD_MONTH = 2'd2,
      FIELD_YEAR  = 2'd3
   } field_t;
   localparam logic [3:0] MONTH_FEB = 4'd2;
   localparam logic [3:0] MONTH_MAX = 4'd12;
   function automatic int date_w(input int yr);
      return yr + 9;
   endfunction
   function automatic int month_lsb(input int yr);
      return yr;
   endfunction
   function automatic int day_lsb(input int yr);
      return yr + 4;
   endfunction
endpackage

// File: rtl/days_in_month.sv
// days_in_month: month length with leap February whenever the two low year bits are zero
module days_in_month
   import date_pkg::*;
(
   input  logic [3:0] month,
   input  logic [1:0] year,
   output logic [4:0] max_day
);
   assign max_day = (month == MONTH_FEB) ? ((year == 2'd0) ? 5'd29 : 5'd28) : (month[0] ? 5'd31 : 5'd30);
endmodule

// File: rtl/date_set_controller.sv
// date_set_controller: button-driven day/month/year edit sequencer; DATE_SET_TIMEOUT_EN adds an idle-edit abort
module date_set_controller
   import date_pkg::*;
#(
   parameter int          YEARRES        = 12,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [YEARRES+8:0] date_current,
   input  logic               btn_mode,
   input  logic               btn_inc,
   input  logic               btn_dec,
   input  logic               btn_cancel,
   output logic [YEARRES+8:0] date_in,
   output logic               date_ow,
   output logic               editing,
   output logic [1:0]         field_sel
);
   localparam int W       = date_w(YEARRES);
   localparam int MON_LSB = month_lsb(YEARRES);
   localparam int DAY_LSB = day_lsb(YEARRES);
   localparam logic [YEARRES-1:0] YEAR_ONE = {{(YEARRES-1){1'b0}}, 1'b1};

   state_t             r_state, w_next_state;
   field_t             r_field;
   logic [W-1:0]       r_buf, w_next_buf;
   logic               r_ow, r_editing;
   logic [4:0]         w_day, w_cur_day, w_cap_day, w_live_max, w_clamp_max;
   logic [3:0]         w_month, w_cur_month, w_cap_month, w_clamp_month;
   logic [YEARRES-1:0] w_year;
   logic [1:0]         w_clamp_year;
   logic               w_inc, w_dec, w_timeout;

   assign w_day       = r_buf[DAY_LSB +: 5];
   assign w_month     = r_buf[MON_LSB +: 4];
   assign w_year      = r_buf[0 +: YEARRES];
   assign w_cur_day   = date_current[DAY_LSB +: 5];
   assign w_cur_month = date_current[MON_LSB +: 4];
   assign w_cap_month = (w_cur_month == 4'd0 || w_cur_month > MONTH_MAX) ? 4'd1 : w_cur_month;
   assign w_clamp_month = (r_state == S_IDLE) ? w_cap_month : w_month;
   assign w_clamp_year  = (r_state == S_IDLE) ? date_current[1:0] : w_year[1:0];
   assign w_cap_day   = (w_cur_day == 5'd0) ? 5'd1 : ((w_cur_day > w_clamp_max) ? w_clamp_max : w_cur_day);
   assign w_inc       = btn_inc & ~btn_dec;
   assign w_dec       = btn_dec & ~btn_inc;

   days_in_month u_live_dim (
      .month   (w_month),
      .year    (w_year[1:0]),
      .max_day (w_live_max)
   );

   days_in_month u_clamp_dim (
      .month   (w_clamp_month),
      .year    (w_clamp_year),
      .max_day (w_clamp_max)
   );

`ifdef DATE_SET_TIMEOUT_EN
   logic [31:0] r_tmo;
   logic        w_any_btn;
   assign w_any_btn = btn_mode | btn_inc | btn_dec | btn_cancel;
   assign w_timeout = !w_any_btn && (r_tmo == TIMEOUT_CYCLES - 32'd1);
   // idle-edit counter: runs only while editing and restarts on any button
   always_ff @(posedge clk)
      r_tmo <= (rst || !r_editing || w_any_btn) ? 32'd0 : r_tmo + 32'd1;
`else
   assign w_timeout = 1'b0 & (TIMEOUT_CYCLES != 32'd0);
`endif

   // next state and edit-buffer update; cancel beats mode beats inc/dec
   always_comb begin
      w_next_state = r_state;
      w_next_buf   = r_buf;
      case (r_state)
         S_IDLE:
            if (btn_mode) begin
               w_next_state = S_EDIT_DAY;
               w_next_buf   = {w_cap_day, w_cap_month, date_current[YEARRES-1:0]};
            end
         S_EDIT_DAY, S_EDIT_MONTH, S_EDIT_YEAR:
            if (btn_cancel || w_timeout)
               w_next_state = S_IDLE;
            else if (btn_mode)
               w_next_state = state_t'(r_state + 3'd1);
            else if (w_inc || w_dec) begin
               if (r_state == S_EDIT_DAY)
                  w_next_buf[DAY_LSB +: 5] = w_inc ? ((w_day >= w_live_max) ? 5'd1 : w_day + 5'd1)
                                                   : ((w_day <= 5'd1) ? w_live_max : w_day - 5'd1);
               else if (r_state == S_EDIT_MONTH)
                  w_next_buf[MON_LSB +: 4] = w_inc ? ((w_month >= MONTH_MAX) ? 4'd1 : w_month + 4'd1)
                                                   : ((w_month <= 4'd1) ? MONTH_MAX : w_month - 4'd1);
               else
                  w_next_buf[0 +: YEARRES] = w_inc ? w_year + YEAR_ONE : w_year - YEAR_ONE;
            end
         S_COMMIT: begin
            w_next_state = S_WRITE;
            w_next_buf[DAY_LSB +: 5] = (w_day > w_clamp_max) ? w_clamp_max : w_day;
         end
         default:
            w_next_state = S_IDLE;
      endcase
   end

   // state, buffer and registered status outputs move together
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_buf     <= '0;
         r_ow      <= 1'b0;
         r_editing <= 1'b0;
         r_field   <= FIELD_NONE;
      end else begin
         r_state   <= w_next_state;
         r_buf     <= w_next_buf;
         r_ow      <= (w_next_state == S_WRITE);
         r_editing <= (w_next_state inside {S_EDIT_DAY, S_EDIT_MONTH, S_EDIT_YEAR});
         r_field   <= (w_next_state inside {S_EDIT_DAY, S_EDIT_MONTH, S_EDIT_YEAR}) ? field_t'(w_next_state[1:0]) : FIELD_NONE;
      end
   end

   assign date_in   = r_buf;
   assign date_ow   = r_ow;
   assign editing   = r_editing;
   assign field_sel = r_field;
endmodule

// File: tb/tb_date_set_controller.sv
// tb_date_set_controller: randomized edit sessions scored against an arithmetic calendar model
module tb_date_set_controller;
   localparam int YR    = 12;
   localparam int TMO_N = 16;
`ifdef DATE_SET_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic          clk = 1'b0, rst = 1'b1;
   logic [YR+8:0] date_current = '0;
   logic          btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_cancel = 1'b0;
   logic [YR+8:0] date_in;
   logic          date_ow, editing;
   logic [1:0]    field_sel;

   always #5 clk = ~clk;

   date_set_controller #(.YEARRES(YR), .TIMEOUT_CYCLES(TMO_N)) dut (
      .clk(clk), .rst(rst), .date_current(date_current),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_cancel(btn_cancel),
      .date_in(date_in), .date_ow(date_ow), .editing(editing), .field_sel(field_sel)
   );

   typedef struct { logic [YR+8:0] d; int c; } exp_t;
   exp_t q[$];
   exp_t e;
   int cyc = 0, n_checks = 0, n_fails = 0;
   bit started = 1'b0, done = 1'b0;
   int m_d = 0, m_m = 0, m_y = 0, m_fld = 0, m_busy = 0, m_tcnt = 0;
   int cd = 0, cm = 0, cy = 0;
   bit m_act = 1'b0;
   logic [YR+8:0] exp_buf = '0;
   logic          exp_edit = 1'b0;
   logic [1:0]    exp_field = 2'd0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int mdays(input int m, input int y);
      if (m == 2) return (y % 4 == 0) ? 29 : 28;
      return (m % 2 == 0) ? 30 : 31;
   endfunction

   function automatic logic [YR+8:0] pk(input int d, input int m, input int y);
      return {d[4:0], m[3:0], y[YR-1:0]};
   endfunction

   function automatic int dmin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("date_in", 32'(date_in), 32'(exp_buf));
         chk("editing", 32'(editing), 32'(exp_edit));
         chk("field_sel", 32'(field_sel), 32'(exp_field));
         chk("date_ow", 32'(date_ow), 32'(q.size() > 0 && cyc == q[0].c));
         if (q.size() > 0 && cyc >= q[0].c) begin
            e = q.pop_front();
            if (date_ow) chk("ow_data", 32'(date_in), 32'(e.d));
         end
         if (done) begin
            chk("pending_writes", 32'(q.size()), 32'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
            $finish;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic sync_model();
      exp_buf   = pk(m_d, m_m, m_y);
      exp_edit  = m_act;
      exp_field = m_act ? 2'(m_fld) : 2'd0;
   endtask

   task automatic set_dc(input int d, input int m, input int y);
      cd = d; cm = m; cy = y;
      date_current = pk(d, m, y);
   endtask

   task automatic step(input bit bm, input bit bi, input bit bd, input bit bc);
      int mx;
      btn_mode = bm; btn_inc = bi; btn_dec = bd; btn_cancel = bc;
      @(posedge clk);
      #1;
      btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_cancel = 1'b0;
      if (m_busy > 0) begin
         if (m_busy == 2) m_d = dmin(m_d, mdays(m_m, m_y));
         m_busy--;
      end else if (!m_act) begin
         if (bm) begin
            m_m = (cm >= 1 && cm <= 12) ? cm : 1;
            m_y = cy;
            m_d = (cd == 0) ? 1 : dmin(cd, mdays(m_m, m_y));
            m_act = 1'b1; m_fld = 1; m_tcnt = 0;
         end
      end else if (bm || bi || bd || bc) begin
         m_tcnt = 0;
         if (bc) m_act = 1'b0;
         else if (bm) begin
            if (m_fld == 3) begin
               m_act = 1'b0; m_busy = 2;
               q.push_back('{pk(dmin(m_d, mdays(m_m, m_y)), m_m, m_y), cyc + 1});
            end else m_fld++;
         end else if (bi != bd) begin
            mx = mdays(m_m, m_y);
            if (m_fld == 1) m_d = bi ? m_d % mx + 1 : (m_d + mx - 2) % mx + 1;
            else if (m_fld == 2) m_m = bi ? m_m % 12 + 1 : (m_m + 10) % 12 + 1;
            else m_y = bi ? (m_y + 1) % (1 << YR) : (m_y + (1 << YR) - 1) % (1 << YR);
         end
      end else if (TMO_EN && m_tcnt == TMO_N - 1) m_act = 1'b0;
      else m_tcnt++;
      sync_model();
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mode(input int n);
      repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_d = 0; m_m = 0; m_y = 0; m_fld = 0; m_busy = 0; m_tcnt = 0; m_act = 1'b0;
      q.delete();
      sync_model();
   endtask

   initial begin
      int n, r;
      repeat (2) @(posedge clk);
      #1;
      sync_model();
      started = 1'b1;
      rst = 1'b0;
      idle(2);
      set_dc(15, 6, 2020); mode(4); idle(3);
      set_dc(29, 2, 2020); mode(1); step(0, 1, 0, 0); step(0, 0, 1, 0); step(0, 0, 0, 1); idle(1);
      set_dc(28, 2, 2021); mode(1); step(0, 1, 0, 0); step(0, 0, 0, 1); idle(1);
      set_dc(31, 1, 2021); mode(2); repeat (3) step(0, 1, 0, 0); mode(2); idle(3);
      set_dc(29, 2, 2020); mode(3); step(0, 1, 0, 0); mode(1); idle(3);
      set_dc(5, 12, 2000); mode(2); step(0, 1, 0, 0); step(0, 1, 1, 0); step(1, 1, 0, 0); step(0, 0, 0, 1); idle(1);
      set_dc(1, 1, 4095); mode(3); step(0, 1, 0, 0); step(0, 0, 1, 0); step(0, 0, 0, 1); idle(1);
      set_dc(0, 14, 7); mode(2); step(0, 0, 0, 1); idle(2);
      set_dc(20, 3, 1999); mode(4); do_reset(); idle(4);
      set_dc(10, 10, 2010); mode(1); idle(9); step(0, 1, 0, 0); idle(20);
      for (int s = 0; s < 60; s++) begin
         set_dc($urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 4095));
         mode(1);
         n = $urandom_range(4, 24);
         for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 11);
            case (r)
               0, 1:    step(1, 0, 0, 0);
               2, 3, 4: step(0, 1, 0, 0);
               5, 6:    step(0, 0, 1, 0);
               7:       step(0, 0, 0, 1);
               8:       step(0, 1, 1, 0);
               9:       step(1, 1, 0, 0);
               default: step(0, 0, 0, 0);
            endcase
         end
         if ($urandom_range(0, 15) == 0) do_reset();
         idle(3);
      end
      done = 1'b1;
      forever @(negedge clk);
   end
endmodule
